stall_scheduler: RTL and testbench
==================================

STALL_SCHEDULER -- requirements
Module: stall_scheduler

Interface
REQ-001 SHALL have parameter MAX_STALL, default 2: max legal consecutive hazard-stall cycles before timeout flag.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1 (legal 1..4): cycles IF/ID is flushed per taken redirect.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port HazardStall  input  1  load-use/branch/JR hazard detected on the instruction in Decode.
REQ-006 SHALL have port BranchTaken  input  1  branch resolved taken in Decode.
REQ-007 SHALL have port JumpTaken  input  1  J/JAL/JR redirect in Decode.
REQ-008 SHALL have port MemBusy  input  1  data memory multi-cycle access in progress.
REQ-009 SHALL have port PCWrite  output  1  PC register load enable.
REQ-010 SHALL have port DecodeRegWrite  output  1  IF/ID register load enable.
REQ-011 SHALL have port MuxControl  output  1  1 = pass Decode control to ID/EX, 0 = insert bubble.
REQ-012 SHALL have port FlushFetch  output  1  clear IF/ID to NOP on next edge.
REQ-013 SHALL have port PipeHold  output  1  freeze ID/EX, EX/MEM, MEM/WB registers.
REQ-014 SHALL have port StallCycles  output  16  saturating count of cycles with PCWrite=0.
REQ-015 SHALL have port RedirectCount  output  16  saturating count of accepted redirects.
REQ-016 SHALL have port StallTimeout  output  1  sticky: hazard stall exceeded MAX_STALL.

Function
REQ-017 SHALL implement FSM states RUN, STALL, MEMWAIT, FLUSH; reset state RUN.
REQ-018 Control outputs SHALL be combinational from state and inputs, priority MemBusy > HazardStall > redirect.
REQ-019 MemBusy=1 (any state): PCWrite=0, DecodeRegWrite=0, MuxControl=1, PipeHold=1, FlushFetch=0; next state MEMWAIT; all other FSM counters hold.
REQ-020 MemBusy=0, HazardStall=1: PCWrite=0, DecodeRegWrite=0, MuxControl=0, PipeHold=0, FlushFetch=0; next state STALL.
REQ-021 MemBusy=0, HazardStall=0, (BranchTaken|JumpTaken)=1, state not FLUSH: all enables 1, MuxControl=1, FlushFetch=1; redirect accepted; next state FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-022 In FLUSH: FlushFetch=1, PCWrite=1, DecodeRegWrite=1, MuxControl=1; BranchTaken/JumpTaken ignored (wrong-path); 2-bit down-counter loaded with FLUSH_CYCLES-1 on entry, decremented each non-MemBusy cycle; exit to RUN after that many FLUSH cycles total.
REQ-023 HazardStall=1 in FLUSH SHALL take priority per REQ-020 but remaining flush count SHALL be retained and resumed when HazardStall drops.
REQ-024 No stall/redirect/MemBusy: PCWrite=1, DecodeRegWrite=1, MuxControl=1, FlushFetch=0, PipeHold=0; next state RUN.
REQ-025 Consecutive-hazard counter (3-bit, saturating at 7) SHALL increment each cycle per REQ-020, hold during MemBusy, clear on any cycle with MemBusy=0 and HazardStall=0.
REQ-026 StallTimeout SHALL set on the edge where the consecutive-hazard counter would exceed MAX_STALL and stay 1 until Reset; it SHALL NOT alter control outputs.
REQ-027 StallCycles SHALL increment on each edge where PCWrite=0, saturate at 16'hFFFF.
REQ-028 RedirectCount SHALL increment on each edge where a redirect is accepted (REQ-021), saturate at 16'hFFFF.

Reset
REQ-029 While Reset=1: PCWrite=0, DecodeRegWrite=0, MuxControl=0, FlushFetch=0, PipeHold=0, regardless of other inputs.
REQ-030 On edge with Reset=1: state RUN, flush/hazard counters 0, StallCycles=0, RedirectCount=0, StallTimeout=0; mid-stall, mid-flush or mid-MEMWAIT reset SHALL abandon the operation with no residual output.
REQ-031 First cycle after Reset deasserts with idle inputs: PCWrite=1, DecodeRegWrite=1, MuxControl=1.

Verification
REQ-032 Idle after reset, 10 cycles no inputs -> enables 1, FlushFetch=0, StallCycles=0, RedirectCount=0.
REQ-033 HazardStall=1 for 2 cycles -> PCWrite=0/MuxControl=0 both cycles, StallCycles=2, StallTimeout=0; 3 cycles -> StallTimeout=1 after third edge, remains 1 after HazardStall drops.
REQ-034 FLUSH_CYCLES=3, BranchTaken pulse 1 cycle, then JumpTaken=1 next cycle -> FlushFetch=1 for 3 cycles, RedirectCount=1 (jump ignored).
REQ-035 MemBusy=1 and HazardStall=1 and BranchTaken=1 same cycle for 4 cycles -> PipeHold=1, MuxControl=1, FlushFetch=0, RedirectCount=0, StallCycles=4, consecutive-hazard counter unchanged.
REQ-036 FLUSH_CYCLES=4, Reset asserted in second FLUSH cycle -> outputs per REQ-029 that cycle, RUN with FlushFetch=0 after release.
REQ-037 StallCycles preloaded by 65540 held stall cycles -> value 16'hFFFF, no wrap.

Source files
------------

// File: rtl/stall_scheduler.sv
// ============================================================================
// Module      : stall_scheduler
// Description : Pipeline stall/flush controller covering hazard stalls,
//               multi-cycle memory waits and taken-redirect IF/ID flushes,
//               plus stall/redirect statistics and a sticky timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_scheduler #(
    parameter int MAX_STALL    = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        HazardStall,
    input  logic        BranchTaken,
    input  logic        JumpTaken,
    input  logic        MemBusy,
    output logic        PCWrite,
    output logic        DecodeRegWrite,
    output logic        MuxControl,
    output logic        FlushFetch,
    output logic        PipeHold,
    output logic [15:0] StallCycles,
    output logic [15:0] RedirectCount,
    output logic        StallTimeout
);

    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_STALL   = 2'd1;
    localparam logic [1:0] c_MEMWAIT = 2'd2;
    localparam logic [1:0] c_FLUSH   = 2'd3;

    localparam logic [1:0] c_flushLoad = 2'(FLUSH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_flushCnt;
    logic [2:0]  r_hazCnt;
    logic [15:0] r_stallCycles;
    logic [15:0] r_redirectCount;
    logic        r_stallTimeout;

    logic        w_flushActive;
    logic        w_accept;
    logic [3:0]  w_hazInc;

    // A flush interrupted by a hazard or memory wait leaves its remaining
    // count behind, so a nonzero count resumes the flush from any state.
    assign w_flushActive = (r_state == c_FLUSH) || (r_flushCnt != 2'd0);
    assign w_hazInc      = {1'b0, r_hazCnt} + 4'd1;

    always_comb begin
        PCWrite        = 1'b0;
        DecodeRegWrite = 1'b0;
        MuxControl     = 1'b0;
        FlushFetch     = 1'b0;
        PipeHold       = 1'b0;
        w_accept       = 1'b0;
        if (Reset) begin
            PCWrite = 1'b0;
        end else if (MemBusy) begin
            MuxControl = 1'b1;
            PipeHold   = 1'b1;
        end else if (HazardStall) begin
            MuxControl = 1'b0;
        end else begin
            PCWrite        = 1'b1;
            DecodeRegWrite = 1'b1;
            MuxControl     = 1'b1;
            if (w_flushActive) begin
                FlushFetch = 1'b1;
            end else if (BranchTaken || JumpTaken) begin
                FlushFetch = 1'b1;
                w_accept   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= c_RUN;
            r_flushCnt      <= 2'd0;
            r_hazCnt        <= 3'd0;
            r_stallCycles   <= 16'd0;
            r_redirectCount <= 16'd0;
            r_stallTimeout  <= 1'b0;
        end else begin
            if (!PCWrite && (r_stallCycles != 16'hFFFF)) begin
                r_stallCycles <= r_stallCycles + 16'd1;
            end
            if (MemBusy) begin
                r_state <= c_MEMWAIT;
            end else if (HazardStall) begin
                r_state  <= c_STALL;
                r_hazCnt <= (r_hazCnt == 3'd7) ? 3'd7 : w_hazInc[2:0];
                if (32'(w_hazInc) > MAX_STALL) begin
                    r_stallTimeout <= 1'b1;
                end
            end else begin
                r_hazCnt <= 3'd0;
                if (w_flushActive) begin
                    r_flushCnt <= r_flushCnt - 2'd1;
                    r_state    <= (r_flushCnt > 2'd1) ? c_FLUSH : c_RUN;
                end else if (w_accept) begin
                    if (r_redirectCount != 16'hFFFF) begin
                        r_redirectCount <= r_redirectCount + 16'd1;
                    end
                    r_flushCnt <= c_flushLoad;
                    r_state    <= (FLUSH_CYCLES > 1) ? c_FLUSH : c_RUN;
                end else begin
                    r_state <= c_RUN;
                end
            end
        end
    end

    assign StallCycles   = r_stallCycles;
    assign RedirectCount = r_redirectCount;
    assign StallTimeout  = r_stallTimeout;

endmodule

`default_nettype wire

// File: tb/tb_stall_scheduler.sv
// ============================================================================
// Module      : tb_stall_scheduler
// Description : Self-checking bench for stall_scheduler; three instances
//               (FLUSH_CYCLES 1, 3, 4) share stimulus and a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stall_scheduler;

    localparam int c_MAX = 2;

    logic Clk = 1'b0;
    logic Reset, HazardStall, BranchTaken, JumpTaken, MemBusy;

    logic        pcw[3], drw[3], mux[3], ff[3], ph[3], to[3];
    logic [15:0] sc[3], rc[3];
    logic [4:0]  ctl[3];

    int checks = 0;
    int errors = 0;

    int fc[3] = '{1, 3, 4};
    int mPend[3], mHaz[3], mSc[3], mRc[3];
    bit mTo[3];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        stall_scheduler #(.MAX_STALL(c_MAX), .FLUSH_CYCLES(g == 0 ? 1 : g + 2)) u_dut (
            .Clk(Clk), .Reset(Reset), .HazardStall(HazardStall),
            .BranchTaken(BranchTaken), .JumpTaken(JumpTaken), .MemBusy(MemBusy),
            .PCWrite(pcw[g]), .DecodeRegWrite(drw[g]), .MuxControl(mux[g]),
            .FlushFetch(ff[g]), .PipeHold(ph[g]), .StallCycles(sc[g]),
            .RedirectCount(rc[g]), .StallTimeout(to[g])
        );
        assign ctl[g] = {pcw[g], drw[g], mux[g], ff[g], ph[g]};
    end

    // Expected {PCWrite, DecodeRegWrite, MuxControl, FlushFetch, PipeHold}.
    function automatic logic [4:0] expCtl(int k);
        if (Reset)       return 5'b00000;
        if (MemBusy)     return 5'b00101;
        if (HazardStall) return 5'b00000;
        if (mPend[k] > 0 || BranchTaken || JumpTaken) return 5'b11110;
        return 5'b11100;
    endfunction

    task automatic stepModel();
        for (int k = 0; k < 3; k++) begin
            logic [4:0] e;
            e = expCtl(k);
            if (Reset) begin
                mPend[k] = 0; mHaz[k] = 0; mSc[k] = 0; mRc[k] = 0; mTo[k] = 0;
            end else begin
                if (!e[4] && mSc[k] < 65535) mSc[k]++;
                if (MemBusy) begin
                end else if (HazardStall) begin
                    if (mHaz[k] + 1 > c_MAX) mTo[k] = 1;
                    if (mHaz[k] < 7) mHaz[k]++;
                end else begin
                    mHaz[k] = 0;
                    if (mPend[k] > 0) mPend[k]--;
                    else if (BranchTaken || JumpTaken) begin
                        if (mRc[k] < 65535) mRc[k]++;
                        mPend[k] = fc[k] - 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        stepModel();
        #1;
    endtask

    task automatic drive(input logic r, input logic h, input logic b, input logic j, input logic m);
        Reset = r; HazardStall = h; BranchTaken = b; JumpTaken = j; MemBusy = m;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge Clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ctl[k] !== 5'b00000) begin
                    errors++;
                    $display("FAIL reset_ctl[%0d]: got %b want 00000", k, ctl[k]);
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ctl[k], sc[k], rc[k], to[k]} !== {5'b11100, 16'd0, 16'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_release[%0d]: got ctl=%b sc=%0d rc=%0d to=%b want 11100/0/0/0",
                         k, ctl[k], sc[k], rc[k], to[k]);
            end
        end
        tick();
    endtask

    task automatic test_idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) tick();
        @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ctl[k], sc[k], rc[k]} !== {5'b11100, 16'd0, 16'd0}) begin
                errors++;
                $display("FAIL idle[%0d]: got ctl=%b sc=%0d rc=%0d want 11100/0/0", k, ctl[k], sc[k], rc[k]);
            end
        end
    endtask

    task automatic test_hazard_timeout();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge Clk);
            checks++;
            if ({pcw[0], mux[0]} !== 2'b00) begin
                errors++;
                $display("FAIL hazard_ctl cyc %0d: got pc=%b mux=%b want 0/0", c, pcw[0], mux[0]);
            end
            tick();
            if (c == 1) begin
                checks++;
                if ({sc[0], to[0]} !== {16'd2, 1'b0}) begin
                    errors++;
                    $display("FAIL hazard_two: got sc=%0d to=%b want 2/0", sc[0], to[0]);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        @(negedge Clk);
        checks++;
        if ({sc[0], to[0], ctl[0]} !== {16'd3, 1'b1, 5'b11100}) begin
            errors++;
            $display("FAIL hazard_timeout: got sc=%0d to=%b ctl=%b want 3/1/11100", sc[0], to[0], ctl[0]);
        end
    endtask

    task automatic test_flush();
        int nFlush;
        nFlush = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, c == 0, c == 1, 1'b0);
            @(negedge Clk);
            if (ff[1]) nFlush++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ctl[k] !== expCtl(k)) begin
                    errors++;
                    $display("FAIL flush_ctl[%0d] cyc %0d: got %b want %b", k, c, ctl[k], expCtl(k));
                end
            end
            tick();
        end
        @(negedge Clk);
        checks++;
        if ({nFlush, rc[1]} !== {32'd3, 16'd1}) begin
            errors++;
            $display("FAIL flush3: got flushes=%0d rc=%0d want 3/1", nFlush, rc[1]);
        end
    endtask

    task automatic test_mem_priority();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            @(negedge Clk);
            checks++;
            if ({ph[0], mux[0], ff[0], pcw[0]} !== 4'b1100) begin
                errors++;
                $display("FAIL mem_ctl cyc %0d: got hold=%b mux=%b ff=%b pc=%b want 1/1/0/0",
                         c, ph[0], mux[0], ff[0], pcw[0]);
            end
            tick();
        end
        // One prior hazard cycle plus two more must reach the timeout only now.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        @(negedge Clk);
        checks++;
        if ({sc[0], rc[0], to[0]} !== {16'd6, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL mem_counts: got sc=%0d rc=%0d to=%b want 6/0/0", sc[0], rc[0], to[0]);
        end
        tick();
        @(negedge Clk);
        checks++;
        if (to[0] !== 1'b1) begin
            errors++;
            $display("FAIL mem_hazhold: got to=%b want 1", to[0]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    endtask

    task automatic test_reset_midflush();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        checks++;
        if (ctl[2] !== 5'b00000) begin
            errors++;
            $display("FAIL midflush_reset: got %b want 00000", ctl[2]);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            checks++;
            if ({ctl[2], rc[2]} !== {5'b11100, 16'd0}) begin
                errors++;
                $display("FAIL midflush_release cyc %0d: got ctl=%b rc=%0d want 11100/0", c, ctl[2], rc[2]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(99) < 2, $urandom_range(99) < 20, $urandom_range(99) < 15,
                  $urandom_range(99) < 10, $urandom_range(99) < 15);
            @(negedge Clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({ctl[k], sc[k], rc[k], to[k]} !== {expCtl(k), 16'(mSc[k]), 16'(mRc[k]), mTo[k]}) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d: got ctl=%b sc=%0d rc=%0d to=%b want ctl=%b sc=%0d rc=%0d to=%b",
                             k, c, ctl[k], sc[k], rc[k], to[k], expCtl(k), mSc[k], mRc[k], mTo[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 65540; c++) tick();
        @(negedge Clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sc[k] !== 16'hFFFF) begin
                errors++;
                $display("FAIL saturate[%0d]: got sc=%h want ffff", k, sc[k]);
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mPend[k] = 0; mHaz[k] = 0; mSc[k] = 0; mRc[k] = 0; mTo[k] = 0;
        end
        #1;
        test_reset();
        test_idle();
        test_hazard_timeout();
        test_flush();
        test_mem_priority();
        test_reset_midflush();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
